// File: rtl/holy_plic_mc.sv
// holy_plic_mc: PLIC-style interrupt controller with NUM_CTX targets behind an AXI-Lite slave.
// Optional feature macro HOLY_PLIC_EDGE_EN adds per-source edge-triggered mode (offset 0x001080).
module holy_plic_mc #(
  parameter int          NUM_IRQS  = 5,
  parameter int          NUM_CTX   = 2,
  parameter int          PRIO_W    = 3,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IRQS-1:0] irq_in,
  input  logic [31:0]         s_axi_awaddr,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [31:0]         s_axi_wdata,
  input  logic [3:0]          s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [31:0]         s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [31:0]         s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic [NUM_CTX-1:0]  ext_irq_o,
  output logic [NUM_IRQS-1:0] ip,
  output logic [NUM_IRQS-1:0] in_service
);

  // Source i lives at bit i of these vectors, so bit 0 of pending/enable is naturally absent.
  logic [NUM_IRQS:1] sync1_q, sync2_q, ip_q, is_q, set_vec, is_clr;
  logic [PRIO_W-1:0] prio_q [1:NUM_IRQS];
  logic [PRIO_W-1:0] prio_n [1:NUM_IRQS];
  logic [NUM_IRQS:1] en_q [NUM_CTX];
  logic [NUM_IRQS:1] en_n [NUM_CTX];
  logic [PRIO_W-1:0] thr_q [NUM_CTX];
  logic [PRIO_W-1:0] thr_n [NUM_CTX];
  logic [4:0]        claim_id [NUM_CTX];
  logic [4:0]        claim_sel;
  logic [PRIO_W-1:0] best_prio;
  logic [NUM_CTX-1:0] irq_n, ext_q;
  logic              aw_rdy_q, bvalid_q, ar_rdy_q, rvalid_q;
  logic [31:0]       rdata_q, rd_data, wr_word, rd_word, wmask;
  logic              wr_fire, rd_fire;
`ifdef HOLY_PLIC_EDGE_EN
  logic [NUM_IRQS:1] sync3_q, edge_q, edge_n;
`endif

  function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [31:0] m);
    return (old & ~m) | (d & m);
  endfunction

  // Handshake: awready/wready (together) and arready are single-cycle registered pulses raised
  // only while the matching valid(s) are up and no response is pending; a transfer completes on
  // the edge where ready and valid are both high, and the response valid then holds until taken.
  assign wr_fire = aw_rdy_q & s_axi_awvalid & s_axi_wvalid;
  assign rd_fire = ar_rdy_q & s_axi_arvalid;
  assign wr_word = (s_axi_awaddr - BASE_ADDR) & ~32'h3;
  assign rd_word = (s_axi_araddr - BASE_ADDR) & ~32'h3;
  assign wmask   = {{8{s_axi_wstrb[3]}}, {8{s_axi_wstrb[2]}}, {8{s_axi_wstrb[1]}}, {8{s_axi_wstrb[0]}}};

  // Post-write register view: reads and claims look at this so a same-cycle write lands first.
  always_comb begin
    prio_n = prio_q;
    en_n   = en_q;
    thr_n  = thr_q;
    is_clr = '0;
`ifdef HOLY_PLIC_EDGE_EN
    edge_n = edge_q;
`endif
    if (wr_fire) begin
      for (int i = 1; i <= NUM_IRQS; i++)
        if (wr_word == (32'(i) << 2))
          prio_n[i] = PRIO_W'(wmerge(32'(prio_q[i]), s_axi_wdata, wmask));
      for (int c = 0; c < NUM_CTX; c++) begin
        if (wr_word == 32'h2000 + 32'h80 * 32'(c))
          en_n[c] = NUM_IRQS'(wmerge(32'({en_q[c], 1'b0}), s_axi_wdata, wmask) >> 1);
        if (wr_word == 32'h20_0000 + 32'h1000 * 32'(c))
          thr_n[c] = PRIO_W'(wmerge(32'(thr_q[c]), s_axi_wdata, wmask));
        if (wr_word == 32'h20_0004 + 32'h1000 * 32'(c))
          for (int i = 1; i <= NUM_IRQS; i++)
            if (s_axi_wdata == 32'(i) && en_q[c][i]) is_clr[i] = 1'b1;
      end
`ifdef HOLY_PLIC_EDGE_EN
      if (wr_word == 32'h1080)
        edge_n = NUM_IRQS'(wmerge(32'({edge_q, 1'b0}), s_axi_wdata, wmask) >> 1);
`endif
    end
  end

  // Interrupt requests use the live registers; claim arbitration uses the post-write view.
  always_comb begin
    irq_n     = '0;
    best_prio = '0;
    for (int c = 0; c < NUM_CTX; c++) claim_id[c] = '0;
    for (int c = 0; c < NUM_CTX; c++) begin
      best_prio = '0;
      for (int i = 1; i <= NUM_IRQS; i++) begin
        if (ip_q[i] && en_q[c][i] && prio_q[i] > thr_q[c]) irq_n[c] = 1'b1;
        if (ip_q[i] && en_n[c][i] && prio_n[i] > thr_n[c] && prio_n[i] > best_prio) begin
          best_prio   = prio_n[i];
          claim_id[c] = 5'(i);
        end
      end
    end
  end

  always_comb begin
    rd_data   = '0;
    claim_sel = '0;
    if (rd_word == 32'h1000) rd_data = 32'({ip_q, 1'b0});
`ifdef HOLY_PLIC_EDGE_EN
    if (rd_word == 32'h1080) rd_data = 32'({edge_n, 1'b0});
`endif
    for (int i = 1; i <= NUM_IRQS; i++)
      if (rd_word == (32'(i) << 2)) rd_data = 32'(prio_n[i]);
    for (int c = 0; c < NUM_CTX; c++) begin
      if (rd_word == 32'h2000 + 32'h80 * 32'(c)) rd_data = 32'({en_n[c], 1'b0});
      if (rd_word == 32'h20_0000 + 32'h1000 * 32'(c)) rd_data = 32'(thr_n[c]);
      if (rd_word == 32'h20_0004 + 32'h1000 * 32'(c)) begin
        rd_data   = 32'(claim_id[c]);
        claim_sel = claim_id[c];
      end
    end
  end

`ifdef HOLY_PLIC_EDGE_EN
  assign set_vec = (edge_q & sync2_q & ~sync3_q) | (~edge_q & sync2_q & ~is_q);
`else
  assign set_vec = sync2_q & ~is_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      ip_q     <= '0;
      is_q     <= '0;
      ext_q    <= '0;
      aw_rdy_q <= 1'b0;
      bvalid_q <= 1'b0;
      ar_rdy_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      for (int i = 1; i <= NUM_IRQS; i++) prio_q[i] <= '0;
      for (int c = 0; c < NUM_CTX; c++) begin
        en_q[c]  <= '0;
        thr_q[c] <= '0;
      end
`ifdef HOLY_PLIC_EDGE_EN
      sync3_q <= '0;
      edge_q  <= '0;
`endif
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
      ext_q   <= irq_n;
      for (int i = 1; i <= NUM_IRQS; i++) prio_q[i] <= prio_n[i];
      for (int c = 0; c < NUM_CTX; c++) begin
        en_q[c]  <= en_n[c];
        thr_q[c] <= thr_n[c];
      end
`ifdef HOLY_PLIC_EDGE_EN
      sync3_q <= sync2_q;
      edge_q  <= edge_n;
`endif
      // A claim beats a same-cycle source assertion for the claimed ID.
      for (int i = 1; i <= NUM_IRQS; i++) begin
        if (rd_fire && claim_sel == 5'(i)) begin
          ip_q[i] <= 1'b0;
          is_q[i] <= 1'b1;
        end else begin
          if (set_vec[i]) ip_q[i] <= 1'b1;
          if (is_clr[i])  is_q[i] <= 1'b0;
        end
      end
      aw_rdy_q <= !aw_rdy_q && s_axi_awvalid && s_axi_wvalid && !bvalid_q;
      if (wr_fire) bvalid_q <= 1'b1;
      else if (s_axi_bready) bvalid_q <= 1'b0;
      ar_rdy_q <= !ar_rdy_q && s_axi_arvalid && !rvalid_q;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
      end else if (s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign s_axi_awready = aw_rdy_q;
  assign s_axi_wready  = aw_rdy_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = ar_rdy_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign ext_irq_o     = ext_q;
  assign ip            = ip_q;
  assign in_service    = is_q;

endmodule

// File: tb/tb_holy_plic_mc.sv
// Directed self-checking bench for holy_plic_mc (default parameters, BASE_ADDR 0).
module tb_holy_plic_mc;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  irq_in;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [3:0]  s_axi_wstrb;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic [1:0]  ext_irq_o;
  logic [4:0]  ip, in_service;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  holy_plic_mc #(.NUM_IRQS(5), .NUM_CTX(2), .PRIO_W(3), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .ext_irq_o(ext_irq_o), .ip(ip), .in_service(in_service)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] prio_a(input int i); return 32'(i) * 32'd4; endfunction
  function automatic logic [31:0] en_a(input int c); return 32'h2000 + 32'h80 * 32'(c); endfunction
  function automatic logic [31:0] thr_a(input int c); return 32'h20_0000 + 32'h1000 * 32'(c); endfunction
  function automatic logic [31:0] clm_a(input int c); return thr_a(c) + 32'd4; endfunction

  // driver tasks
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 20) begin tick(1); n++; end
    if (!s_axi_awready) check("aw_timeout", 32'(s_axi_awready), 32'd1);
    tick(1);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b1;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin tick(1); n++; end
    if (!s_axi_bvalid) check("b_timeout", 32'(s_axi_bvalid), 32'd1);
    tick(1);
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
    int n;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 20) begin tick(1); n++; end
    if (!s_axi_arready) check("ar_timeout", 32'(s_axi_arready), 32'd1);
    tick(1);
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin tick(1); n++; end
    if (!s_axi_rvalid) check("r_timeout", 32'(s_axi_rvalid), 32'd1);
    d = s_axi_rdata;
    s_axi_rready = 1'b1;
    tick(1);
    s_axi_rready = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    axi_write(a, d, 4'hf);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] e);
    logic [31:0] d;
    axi_read(a, d);
    check(tag, d, e);
  endtask

  // scoreboard: expected claim IDs are queued, then popped as each claim returns
  task automatic claim_chk(input string tag, input int c);
    logic [31:0] d, e;
    axi_read(clm_a(c), d);
    e = exp_q.pop_front();
    check(tag, d, e);
  endtask

  initial begin
    int n;
    logic ok;
    logic [31:0] d8;
    rst_n = 1'b0; irq_in = '0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    tick(3);
    check("rst_ip", 32'(ip), 32'd0);
    check("rst_in_service", 32'(in_service), 32'd0);
    check("rst_ext_irq", 32'(ext_irq_o), 32'd0);
    check("rst_ready", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd0);
    check("rst_valid", 32'({s_axi_bvalid, s_axi_rvalid}), 32'd0);
    check("rst_rdata", s_axi_rdata, 32'd0);
    check("rst_resp", 32'({s_axi_bresp, s_axi_rresp}), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // register map, read-zero holes and byte strobes
    wr(prio_a(1), 32'd7);
    rd_chk("prio1_rw", prio_a(1), 32'd7);
    axi_write(prio_a(1), 32'd3, 4'h0);
    rd_chk("prio1_strb0", prio_a(1), 32'd7);
    wr(prio_a(0), 32'd5);
    rd_chk("prio0_zero", prio_a(0), 32'd0);
    axi_write(thr_a(0), 32'hffff_ffff, 4'b0010);
    rd_chk("thr_strb_byte1", thr_a(0), 32'd0);
    axi_write(thr_a(0), 32'h0000_0006, 4'b0001);
    rd_chk("thr_strb_byte0", thr_a(0), 32'd6);
    wr(en_a(0), 32'hffff_ffff);
    rd_chk("en0_bits", en_a(0), 32'h3e);
    wr(en_a(2), 32'hff);
    rd_chk("en_ctx2_zero", en_a(2), 32'd0);
    wr(32'h3000, 32'h1234);
    rd_chk("unmapped_zero", 32'h3000, 32'd0);
    wr(32'h1080, 32'h10);
`ifdef HOLY_PLIC_EDGE_EN
    rd_chk("edge_reg", 32'h1080, 32'h10);
`else
    rd_chk("edge_reg_absent", 32'h1080, 32'd0);
`endif
    wr(32'h1080, 32'd0);
    wr(prio_a(1), 32'd0); wr(en_a(0), 32'd0); wr(thr_a(0), 32'd0);

    // basic interrupt path and claim
    wr(prio_a(2), 32'd3); wr(en_a(0), 32'h4); wr(thr_a(0), 32'd1);
    irq_in[1] = 1'b1;
    n = 0;
    while (!ext_irq_o[0] && n < 8) begin tick(1); n++; end
    check("r31_latency", 32'(n), 32'd4);
    check("r31_ip", 32'(ip), 32'b00010);
    exp_q.push_back(32'd2);
    claim_chk("r31_claim", 0);
    check("r31_ext_drop", 32'(ext_irq_o[0]), 32'd0);
    check("r31_in_service", 32'(in_service), 32'b00010);

    // held level does not re-pend until completion; foreign-context complete ignored
    tick(5);
    check("r34_no_repend", 32'(ip), 32'd0);
    wr(clm_a(1), 32'd2);
    check("r34_ctx1_ignored", 32'(in_service), 32'b00010);
    wr(clm_a(0), 32'd2);
    check("r34_in_service_clr", 32'(in_service), 32'd0);
    check("r34_repend", 32'(ip), 32'b00010);
    exp_q.push_back(32'd2);
    claim_chk("r34_claim2", 0);
    irq_in[1] = 1'b0;
    tick(3);
    wr(clm_a(0), 32'd2);
    tick(4);
    check("r34_quiet", 32'({ip, in_service}), 32'd0);

    // threshold gating
    wr(thr_a(0), 32'd3);
    irq_in[1] = 1'b1;
    tick(6);
    check("r33_pending", 32'(ip), 32'b00010);
    check("r33_gated", 32'(ext_irq_o[0]), 32'd0);
    wr(thr_a(0), 32'd2);
    check("r33_open", 32'(ext_irq_o[0]), 32'd1);
    exp_q.push_back(32'd2);
    claim_chk("r33_claim", 0);
    irq_in[1] = 1'b0;
    tick(3);
    wr(clm_a(0), 32'd2);

    // priority ties go to lowest ID; higher priority wins
    wr(en_a(0), 32'h0a); wr(prio_a(1), 32'd5); wr(prio_a(3), 32'd5); wr(thr_a(0), 32'd0);
    irq_in = 5'b00101;
    tick(4);
    irq_in = '0;
    tick(1);
    check("r32_ip", 32'(ip), 32'b00101);
    exp_q.push_back(32'd1); exp_q.push_back(32'd3); exp_q.push_back(32'd0);
    claim_chk("r32_tie_first", 0);
    claim_chk("r32_tie_second", 0);
    claim_chk("r32_empty", 0);
    wr(clm_a(0), 32'd1); wr(clm_a(0), 32'd3);
    wr(prio_a(3), 32'd6);
    irq_in = 5'b00101;
    tick(4);
    irq_in = '0;
    tick(1);
    exp_q.push_back(32'd3); exp_q.push_back(32'd1);
    claim_chk("prio_high_first", 0);
    claim_chk("prio_low_second", 0);
    wr(clm_a(0), 32'd3); wr(clm_a(0), 32'd1);
    check("prio_done", 32'(in_service), 32'd0);

    // priority 0 never interrupts or gets claimed
    wr(en_a(0), 32'h10); wr(prio_a(4), 32'd0);
    irq_in[3] = 1'b1;
    tick(4);
    irq_in[3] = 1'b0;
    tick(2);
    check("p0_pending", 32'(ip), 32'b01000);
    check("p0_no_irq", 32'(ext_irq_o[0]), 32'd0);
    exp_q.push_back(32'd0);
    claim_chk("p0_claim_zero", 0);
    check("p0_still_pending", 32'(ip), 32'b01000);
    wr(prio_a(4), 32'd1);
    check("p1_irq", 32'(ext_irq_o[0]), 32'd1);
    exp_q.push_back(32'd4);
    claim_chk("p1_claim", 0);
    check("p1_irq_drop", 32'(ext_irq_o[0]), 32'd0);
    wr(clm_a(0), 32'd4);

    // same-cycle write and claim: write applies first
    wr(en_a(0), 32'd0); wr(prio_a(2), 32'd3); wr(thr_a(0), 32'd1);
    irq_in[1] = 1'b1;
    tick(4);
    check("wf_pending", 32'(ip), 32'b00010);
    check("wf_no_irq", 32'(ext_irq_o[0]), 32'd0);
    fork
      axi_write(en_a(0), 32'h4, 4'hf);
      axi_read(clm_a(0), d8);
    join
    check("wf_claim_sees_write", d8, 32'd2);
    check("wf_in_service", 32'(in_service), 32'b00010);
    irq_in[1] = 1'b0;
    tick(3);
    wr(clm_a(0), 32'd2);
    tick(3);
    check("wf_quiet", 32'({ip, in_service}), 32'd0);

    // write response backpressure
    s_axi_awaddr = thr_a(1); s_axi_wdata = 32'd5; s_axi_wstrb = 4'hf;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 20) begin tick(1); n++; end
    check("r35_aw_first", 32'(s_axi_awready & s_axi_wready), 32'd1);
    tick(1);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("r35_bvalid", 32'(s_axi_bvalid), 32'd1);
    check("r35_bresp", 32'(s_axi_bresp), 32'd0);
    s_axi_wdata = 32'd6; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      if (!s_axi_bvalid || s_axi_awready || s_axi_wready) ok = 1'b0;
    end
    check("r35_hold", 32'(ok), 32'd1);
    s_axi_bready = 1'b1;
    tick(1);
    s_axi_bready = 1'b0;
    check("r35_b_done", 32'(s_axi_bvalid), 32'd0);
    n = 0;
    while (!s_axi_awready && n < 20) begin tick(1); n++; end
    check("r35_aw_after_b", 32'(s_axi_awready), 32'd1);
    tick(1);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b1;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin tick(1); n++; end
    tick(1);
    s_axi_bready = 1'b0;
    rd_chk("r35_thr1", thr_a(1), 32'd6);

`ifdef HOLY_PLIC_EDGE_EN
    // edge mode: pulses while in service pend once, held level pends once
    wr(32'h1080, 32'h10); wr(prio_a(4), 32'd2); wr(en_a(0), 32'h10); wr(thr_a(0), 32'd0);
    irq_in[3] = 1'b1; tick(2); irq_in[3] = 1'b0; tick(4);
    check("e_first_pend", 32'(ip), 32'b01000);
    exp_q.push_back(32'd4);
    claim_chk("e_claim1", 0);
    irq_in[3] = 1'b1; tick(2); irq_in[3] = 1'b0; tick(3);
    irq_in[3] = 1'b1; tick(2); irq_in[3] = 1'b0; tick(4);
    check("e_pulses_pend", 32'(ip), 32'b01000);
    check("e_in_service", 32'(in_service), 32'b01000);
    exp_q.push_back(32'd4);
    claim_chk("e_claim2", 0);
    check("e_ip_cleared", 32'(ip), 32'd0);
    irq_in[3] = 1'b1; tick(5);
    check("e_level_edge", 32'(ip), 32'b01000);
    exp_q.push_back(32'd4);
    claim_chk("e_claim3", 0);
    tick(5);
    check("e_held_no_pend", 32'(ip), 32'd0);
    wr(clm_a(0), 32'd4);
    tick(4);
    check("e_after_complete", 32'({ip, in_service}), 32'd0);
    irq_in[3] = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/holy_plic_mc.md
HOLY_PLIC_MC -- requirements
Module: holy_plic_mc

Interface
REQ-001 SHALL have parameter NUM_IRQS, default 5, number of sources, IDs 1..NUM_IRQS, legal range 1..31.
REQ-002 SHALL have parameter NUM_CTX, default 2, number of interrupt targets (contexts), legal range 1..4.
REQ-003 SHALL have parameter PRIO_W, default 3, priority/threshold width in bits.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0000_0000, AXI-Lite base address.
REQ-005 SHALL have port clk, input, 1, single clock for all logic.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port irq_in, input, NUM_IRQS, asynchronous IRQ lines; bit i-1 is source i.
REQ-008 SHALL have AXI-Lite slave ports s_axi_aw*/w*/b*/ar*/r*, 32-bit address and data, 4-bit wstrb, 2-bit resp.
REQ-009 SHALL have port ext_irq_o, output, NUM_CTX, per-context interrupt request.
REQ-010 SHALL have port ip, output, NUM_IRQS, pending bits (debug).
REQ-011 SHALL have port in_service, output, NUM_IRQS, claimed-not-completed bits (debug).

Function
REQ-012 SHALL pass each irq_in bit through a 2-flop synchronizer before use.
REQ-013 SHALL use offsets relative to BASE_ADDR: 0x000000+4*i priority[i]; 0x001000 pending (RO); 0x002000+0x80*c enable[c]; 0x200000+0x1000*c threshold[c]; 0x200004+0x1000*c claim/complete[c].
REQ-014 SHALL treat priority[0], bit 0 of pending/enable, unmapped offsets and c>=NUM_CTX as read-zero, write-ignored.
REQ-015 SHALL set ip[i] in level mode when the synced input is high, ip[i]=0 and in_service[i]=0.
REQ-016 SHALL drive ext_irq_o[c] high when some i has ip[i], enable[c][i] and priority[i]>threshold[c]; priority 0 never interrupts.
REQ-017 SHALL register ext_irq_o, giving one cycle of latency from the ip/enable/priority/threshold change.
REQ-018 SHALL return, on a claim read of context c, the eligible ID with the highest priority, ties to the lowest ID, or 0 if there is none.
REQ-019 SHALL, at AR acceptance of a claim with a nonzero ID, clear ip[ID] and set in_service[ID] in the same cycle.
REQ-020 SHALL, on a complete write (data=ID) to context c, clear in_service[ID] only if ID is in 1..NUM_IRQS and enable[c][ID]=1; other writes are ignored.
REQ-021 SHALL give the claim precedence when a claim and a new source assertion occur in the same cycle; the source re-pends only after completion.
REQ-022 SHALL assert awready and wready together for one cycle only when awvalid, wvalid and no bvalid are outstanding; bvalid follows next cycle with bresp=OKAY and holds until bready.
REQ-023 SHALL assert arready for one cycle when arvalid and no rvalid are outstanding; rvalid follows next cycle with rresp=OKAY and rdata held until rready.
REQ-024 SHALL apply wstrb byte-wise to priority, enable and threshold registers; complete writes ignore wstrb.
REQ-025 SHALL, if a write and a read are accepted in the same cycle, apply the write first; a claim then sees the updated state.

Reset
REQ-026 SHALL, while rst_n is low, clear synchronizers, ip, in_service, priority, enable, threshold, ext_irq_o, awready, wready, bvalid, arready, rvalid and rdata; bresp and rresp are 0.
REQ-027 SHALL abandon an in-flight AXI transaction on reset with no response issued; the first sample after release needs 2 cycles to reach ip.

Configuration
REQ-028 SHALL, when HOLY_PLIC_EDGE_EN is defined, add an RW edge-mode register at offset 0x001080, one bit per source, reset 0.
REQ-029 SHALL, with HOLY_PLIC_EDGE_EN defined and the edge bit set, set ip[i] on a synced rising edge, even while in_service[i]=1, without re-setting it on a held level.
REQ-030 SHALL, without HOLY_PLIC_EDGE_EN, operate all sources in level mode and treat offset 0x001080 as read-zero, write-ignored.

Verification
REQ-031 SHALL cover: priority[2]=3, enable[0]=0x4, threshold[0]=1, irq_in[1]=1 -> ext_irq_o[0]=1 within 4 cycles; claim[0] reads 2; ext_irq_o[0]=0 next cycle.
REQ-032 SHALL cover: sources 1 and 3 both priority 5 and pending -> claim returns 1; a second claim returns 3; a third claim returns 0.
REQ-033 SHALL cover: source 2 with threshold[0]=3 and priority 3 -> ext_irq_o[0] stays 0; writing threshold 2 -> ext_irq_o[0]=1.
REQ-034 SHALL cover: claim 2 while irq_in[1] is held high -> no re-pend; complete 2 -> ip[2]=1 again 1 cycle later; complete 2 from context 1 with enable[1][2]=0 -> ignored.
REQ-035 SHALL cover: bready held low 5 cycles -> bvalid stays high, awready stays 0; new AW/W is accepted after the B handshake.
REQ-036 SHALL cover, with HOLY_PLIC_EDGE_EN defined and edge bit 4 set: two irq_in[3] pulses while in_service[4]=1 -> ip[4]=1 once; a held level -> no further pends.
